// File: rtl/channel_router_pkg.sv
// Shared types and helpers for channel_router: FSM states, direction encoding,
// and the legal-command check (exactly one channel, exactly one direction).
package channel_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest channel vector the legality check accepts; narrower selects are zero-extended.
  localparam int MAX_CH = 32;

  function automatic logic cmd_legal(input logic [MAX_CH-1:0] sel,
                                     input logic up,
                                     input logic down);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_CH; i++) ones += int'(sel[i]);
    return (ones == 1) && (up ^ down);
  endfunction

endpackage

// File: rtl/channel_hold_timer.sv
// Loadable down-counter that times how long a channel line is held high.
// done is high whenever the count has reached zero; decrement stops there.
module channel_hold_timer #(
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/channel_router.sv
// N-channel send/receive command router: one registered ch_up/ch_down pulse per
// accepted command. Optional one-entry pending command under CHANNEL_ROUTER_QUEUE_EN.
//
// Handshake: request is a strobe, not valid/ready; a command is taken only on a
// sampled 0->1 transition of request, and ch_sel/up/down matter only at that edge.
module channel_router
  import channel_router_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int HOLD_CYCLES = 4,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1),
  localparam int IDX_W       = $clog2(NUM_CH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] ch_sel,
  input  logic              request,
  input  logic              up,
  input  logic              down,
  output logic [NUM_CH-1:0] ch_up,
  output logic [NUM_CH-1:0] ch_down,
  output logic              busy,
  output logic              err,
  output state_t            fsm_state
);

  state_t            state, state_next;
  logic              request_q;
  logic              req_rise;
  logic              legal;
  logic [IDX_W-1:0]  sel_idx;
  logic              start;
  logic [IDX_W-1:0]  start_idx;
  logic              start_dir;
  logic [NUM_CH-1:0] start_mask;
  logic              err_next;
  logic              dec;
  logic              done;

`ifdef CHANNEL_ROUTER_QUEUE_EN
  logic             pend_valid;
  logic             pend_store;
  logic             pend_clear;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_dir;
`endif

  assign req_rise   = request & ~request_q;
  assign legal      = cmd_legal(MAX_CH'(ch_sel), up, down);
  assign start_mask = NUM_CH'(1) << start_idx;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_idx  = sel_idx;
    start_dir  = up ? DIR_UP : DIR_DOWN;
    err_next   = 1'b0;
    dec        = 1'b0;
`ifdef CHANNEL_ROUTER_QUEUE_EN
    pend_store = 1'b0;
    pend_clear = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (req_rise) begin
          if (legal) begin
            state_next = DRIVE;
            start      = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (done) state_next = GAP;
        else      dec        = 1'b1;
        if (req_rise) begin
`ifdef CHANNEL_ROUTER_QUEUE_EN
          if (legal && !pend_valid) pend_store = 1'b1;
          else                      err_next   = 1'b1;
`else
          err_next = 1'b1;
`endif
        end
      end
      GAP: begin
        state_next = IDLE;
`ifdef CHANNEL_ROUTER_QUEUE_EN
        // A command arriving in the gap with nothing pending launches directly,
        // which is the same as storing it and consuming it on this edge.
        if (pend_valid) begin
          state_next = DRIVE;
          start      = 1'b1;
          start_idx  = pend_idx;
          start_dir  = pend_dir;
          pend_clear = 1'b1;
          err_next   = req_rise;
        end else if (req_rise && legal) begin
          state_next = DRIVE;
          start      = 1'b1;
        end else begin
          err_next = req_rise;
        end
`else
        err_next = req_rise;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // request_q follows request even in reset so a level held through reset
  // is not mistaken for a fresh command once reset releases.
  always_ff @(posedge Clk) begin
    request_q <= request;
    if (Reset) begin
      state   <= IDLE;
      ch_up   <= '0;
      ch_down <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      err   <= err_next;
      if (start) begin
        ch_up   <= (start_dir == DIR_UP) ? start_mask : '0;
        ch_down <= (start_dir == DIR_UP) ? '0 : start_mask;
      end else if (state_next != DRIVE) begin
        ch_up   <= '0;
        ch_down <= '0;
      end
    end
  end

`ifdef CHANNEL_ROUTER_QUEUE_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_dir   <= DIR_DOWN;
    end else if (pend_store) begin
      pend_valid <= 1'b1;
      pend_idx   <= sel_idx;
      pend_dir   <= up ? DIR_UP : DIR_DOWN;
    end else if (pend_clear) begin
      pend_valid <= 1'b0;
    end
  end
`endif

  channel_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (start),
    .load_val (CNT_W'(HOLD_CYCLES - 1)),
    .dec      (dec),
    .done     (done)
  );

endmodule

// File: tb/tb_channel_router.sv
// Bench for channel_router (4 ch, hold 4) plus a 2 ch / hold 1 instance; reference
// model works on pulse start times and a pending list. Honours CHANNEL_ROUTER_QUEUE_EN.
module tb_channel_router;
  import channel_router_pkg::*;

  localparam int N = 4;
  localparam int H = 4;
`ifdef CHANNEL_ROUTER_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic         Clk;
  logic         Reset;
  logic [N-1:0] ch_sel;
  logic         request, up, down;
  logic [N-1:0] ch_up, ch_down;
  logic         busy, err;
  state_t       st1;

  logic [1:0]   sel2;
  logic         req2, up2, down2;
  logic [1:0]   up_o2, down_o2;
  logic         busy2, err2;
  state_t       st2;

  int total = 0;
  int bad   = 0;

  // reference model state
  int           k = 0;
  bit           cur_active = 0;
  int           cur_s = 0;
  int           cur_ch = 0;
  bit           cur_dir = 0;
  int           pend_ch[$];
  bit           pend_dir[$];
  bit           req_prev = 0;
  logic [N-1:0] exp_up = '0, exp_down = '0;
  logic         exp_busy = 0, exp_err = 0;
  logic [N:0]   exp_q[$];

  channel_router #(.NUM_CH(N), .HOLD_CYCLES(H)) dut (
    .Clk(Clk), .Reset(Reset), .ch_sel(ch_sel), .request(request), .up(up), .down(down),
    .ch_up(ch_up), .ch_down(ch_down), .busy(busy), .err(err), .fsm_state(st1)
  );

  channel_router #(.NUM_CH(2), .HOLD_CYCLES(1)) dut2 (
    .Clk(Clk), .Reset(Reset), .ch_sel(sel2), .request(req2), .up(up2), .down(down2),
    .ch_up(up_o2), .ch_down(down_o2), .busy(busy2), .err(err2), .fsm_state(st2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int sel_index(input logic [N-1:0] s);
    for (int i = 0; i < N; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic launch(input int s, input int ch, input bit d);
    logic [N-1:0] m;
    cur_active = 1;
    cur_s      = s;
    cur_ch     = ch;
    cur_dir    = d;
    m          = '0;
    m[ch]      = 1'b1;
    exp_q.push_back({d, m});
  endtask

  task automatic set_in(input logic [N-1:0] s, input logic r, input logic u, input logic d);
    ch_sel  = s;
    request = r;
    up      = u;
    down    = d;
  endtask

  task automatic set2(input logic [1:0] s, input logic r, input logic u, input logic d);
    sel2  = s;
    req2  = r;
    up2   = u;
    down2 = d;
  endtask

  // One clock edge: the model consumes the inputs present at the edge, then
  // outputs are sampled 1 time unit later.
  task automatic tick();
    bit rise, lg, busy_b, gap_edge;
    @(posedge Clk);
    rise     = request && !req_prev;
    req_prev = request;
    k++;
    exp_err  = 1'b0;
    if (Reset) begin
      cur_active = 0;
      pend_ch.delete();
      pend_dir.delete();
    end else begin
      lg       = ($countones(ch_sel) == 1) && (up != down);
      busy_b   = cur_active && (k <= cur_s + H + 1);
      gap_edge = cur_active && (k == cur_s + H + 1);
      if (gap_edge) cur_active = 0;
      if (rise) begin
        if (!busy_b) begin
          if (lg) launch(k, sel_index(ch_sel), up);
          else    exp_err = 1'b1;
        end else if (QEN && lg && pend_ch.size() == 0 && gap_edge) begin
          launch(k, sel_index(ch_sel), up);
        end else if (QEN && lg && pend_ch.size() == 0) begin
          pend_ch.push_back(sel_index(ch_sel));
          pend_dir.push_back(up);
        end else begin
          exp_err = 1'b1;
        end
      end
      if (gap_edge && pend_ch.size() > 0) launch(k, pend_ch.pop_front(), pend_dir.pop_front());
    end
    exp_up   = '0;
    exp_down = '0;
    if (cur_active && k >= cur_s && k <= cur_s + H - 1) begin
      if (cur_dir) exp_up[cur_ch] = 1'b1;
      else         exp_down[cur_ch] = 1'b1;
    end
    exp_busy = cur_active && (k <= cur_s + H);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_in(4'b0010, 1'b1, 1'b1, 1'b0);
    repeat (2) begin
      tick();
      total++;
      if (ch_up !== '0 || ch_down !== '0 || busy !== 1'b0 || err !== 1'b0 || st1 !== IDLE) begin
        bad++;
        $display("FAIL reset_hold: up=%b down=%b busy=%b err=%b st=%0d want 0000 0000 0 0 IDLE",
                 ch_up, ch_down, busy, err, st1);
      end
    end
    Reset = 1'b0;
    repeat (3) begin
      tick();
      total++;
      if (ch_up !== '0 || ch_down !== '0 || busy !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL reset_release_held_req: up=%b down=%b busy=%b err=%b want all 0",
                 ch_up, ch_down, busy, err);
      end
    end
    request = 1'b0;
    tick();
    request = 1'b1;
    tick();
    total++;
    if (ch_up !== 4'b0010 || ch_down !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_then_rise: up=%b down=%b busy=%b want 0010 0000 1", ch_up, ch_down, busy);
    end
    request = 1'b0;
    repeat (5) begin
      tick();
      total++;
      if (ch_up !== exp_up || ch_down !== exp_down || busy !== exp_busy || err !== exp_err) begin
        bad++;
        $display("FAIL reset_tail: up=%b/%b down=%b/%b busy=%b/%b err=%b/%b (got/want)",
                 ch_up, exp_up, ch_down, exp_down, busy, exp_busy, err, exp_err);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [N-1:0] eu;
    logic         eb;
    set_in(4'b0100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) set_in(4'b1000, 1'b0, 1'b0, 1'b1);
      eu = (i <= H - 1) ? 4'b0100 : 4'b0000;
      eb = (i <= H);
      total++;
      if (ch_up !== eu || ch_down !== '0 || busy !== eb || err !== 1'b0) begin
        bad++;
        $display("FAIL single_pulse[%0d]: up=%b down=%b busy=%b err=%b want %b 0000 %b 0",
                 i, ch_up, ch_down, busy, err, eu, eb);
      end
    end
  endtask

  task automatic test_illegal();
    logic [N-1:0] sels[3];
    logic         ups[3];
    logic         dns[3];
    sels = '{4'b0110, 4'b0001, 4'b0000};
    ups  = '{1'b1, 1'b1, 1'b0};
    dns  = '{1'b0, 1'b1, 1'b1};
    for (int p = 0; p < 3; p++) begin
      set_in(sels[p], 1'b1, ups[p], dns[p]);
      tick();
      total++;
      if (err !== 1'b1 || ch_up !== '0 || ch_down !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL illegal_%0d: err=%b up=%b down=%b busy=%b want 1 0000 0000 0",
                 p, err, ch_up, ch_down, busy);
      end
      set_in('0, 1'b0, 1'b0, 1'b0);
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || ch_up !== '0 || ch_down !== '0) begin
        bad++;
        $display("FAIL illegal_%0d_after: err=%b busy=%b up=%b down=%b want 0 0 0000 0000",
                 p, err, busy, ch_up, ch_down);
      end
    end
  endtask

  task automatic test_busy_request();
    logic [N-1:0] eu, ed;
    logic         eb, ee;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:       set_in(4'b0001, 1'b1, 1'b0, 1'b1);
        2:       set_in(4'b1000, 1'b1, 1'b1, 1'b0);
        4:       set_in(4'b0010, 1'b1, 1'b1, 1'b0);
        default: set_in(4'b0000, 1'b0, 1'b0, 1'b0);
      endcase
      tick();
      ed = (i <= 3) ? 4'b0001 : 4'b0000;
      eu = (QEN && i >= 5 && i <= 8) ? 4'b1000 : 4'b0000;
      eb = QEN ? (i <= 9) : (i <= 4);
      ee = (i == 4) || (i == 2 && !QEN);
      total++;
      if (ch_up !== eu || ch_down !== ed || busy !== eb || err !== ee) begin
        bad++;
        $display("FAIL busy_request[%0d]: up=%b/%b down=%b/%b busy=%b/%b err=%b/%b (got/want)",
                 i, ch_up, eu, ch_down, ed, busy, eb, err, ee);
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    logic [N-1:0] ed;
    logic         eb;
    set_in(4'b0100, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(4'b0010, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(4'b0010, 1'b1, 1'b0, 1'b1);
    tick();
    total++;
    if (ch_up !== 4'b0100 || ch_down !== '0 || busy !== 1'b1 || err !== !QEN) begin
      bad++;
      $display("FAIL reset_mid_pre: up=%b down=%b busy=%b err=%b want 0100 0000 1 %b",
               ch_up, ch_down, busy, err, !QEN);
    end
    Reset = 1'b1;
    set_in(4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (ch_up !== '0 || ch_down !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_drop: up=%b down=%b busy=%b err=%b want all 0", ch_up, ch_down, busy, err);
    end
    Reset = 1'b0;
    tick();
    set_in(4'b1000, 1'b1, 1'b0, 1'b1);
    for (int r = 1; r <= 8; r++) begin
      tick();
      if (r == 1) request = 1'b0;
      ed = (r <= H) ? 4'b1000 : 4'b0000;
      eb = (r <= H + 1);
      total++;
      if (ch_up !== '0 || ch_down !== ed || busy !== eb || err !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_after[%0d]: up=%b down=%b/%b busy=%b/%b err=%b (got/want)",
                 r, ch_up, ch_down, ed, busy, eb, err);
      end
    end
  endtask

  task automatic test_small_hold();
    set2(2'b10, 1'b1, 1'b1, 1'b0);
    tick();
    set2(2'b00, 1'b0, 1'b0, 1'b0);
    total++;
    if (up_o2 !== 2'b10 || down_o2 !== 2'b00 || busy2 !== 1'b1) begin
      bad++;
      $display("FAIL small_pulse: up=%b down=%b busy=%b want 10 00 1", up_o2, down_o2, busy2);
    end
    tick();
    total++;
    if (up_o2 !== 2'b00 || busy2 !== 1'b1) begin
      bad++;
      $display("FAIL small_gap: up=%b busy=%b want 00 1", up_o2, busy2);
    end
    tick();
    total++;
    if (busy2 !== 1'b0 || st2 !== IDLE || up_o2 !== 2'b00 || down_o2 !== 2'b00) begin
      bad++;
      $display("FAIL small_idle: busy=%b st=%0d up=%b down=%b want 0 IDLE 00 00", busy2, st2, up_o2, down_o2);
    end
    set2(2'b11, 1'b1, 1'b1, 1'b0);
    tick();
    set2(2'b00, 1'b0, 1'b0, 1'b0);
    total++;
    if (err2 !== 1'b1 || busy2 !== 1'b0 || up_o2 !== 2'b00) begin
      bad++;
      $display("FAIL small_illegal: err=%b busy=%b up=%b want 1 0 00", err2, busy2, up_o2);
    end
    tick();
    set2(2'b01, 1'b1, 1'b0, 1'b1);
    tick();
    total++;
    if (down_o2 !== 2'b01 || up_o2 !== 2'b00 || err2 !== 1'b0) begin
      bad++;
      $display("FAIL small_down: down=%b up=%b err=%b want 01 00 0", down_o2, up_o2, err2);
    end
    set2(2'b00, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total++;
    if (down_o2 !== 2'b00 || busy2 !== 1'b0 || err2 !== 1'b0) begin
      bad++;
      $display("FAIL small_reset: down=%b busy=%b err=%b want 00 0 0", down_o2, busy2, err2);
    end
    tick();
  endtask

  task automatic test_random();
    bit           prev_on;
    logic [N:0]   got, want;
    int           r;
    exp_q.delete();
    prev_on = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c < 580) begin
        if ($urandom_range(0, 3) == 0) request = ~request;
        if ($urandom_range(0, 9) < 7) begin
          ch_sel = '0;
          ch_sel[$urandom_range(0, N - 1)] = 1'b1;
        end else begin
          ch_sel = N'($urandom_range(0, 15));
        end
        r = $urandom_range(0, 9);
        if (r < 4)      begin up = 1'b1; down = 1'b0; end
        else if (r < 8) begin up = 1'b0; down = 1'b1; end
        else            begin up = 1'($urandom_range(0, 1)); down = 1'($urandom_range(0, 1)); end
      end else begin
        set_in('0, 1'b0, 1'b0, 1'b0);
      end
      tick();
      total++;
      if (ch_up !== exp_up || ch_down !== exp_down || busy !== exp_busy || err !== exp_err) begin
        bad++;
        $display("FAIL random[%0d]: up=%b/%b down=%b/%b busy=%b/%b err=%b/%b (got/want)",
                 c, ch_up, exp_up, ch_down, exp_down, busy, exp_busy, err, exp_err);
      end
      if (((ch_up | ch_down) != '0) && !prev_on) begin
        got = {(ch_up != '0), (ch_up | ch_down)};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL random_pulse[%0d]: dir_mask=%b want %b", c, got, want);
        end
      end
      prev_on = ((ch_up | ch_down) != '0);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_unseen_pulses: left=%0d want 0", exp_q.size());
    end
  endtask

  initial begin
    Reset = 1'b1;
    set_in('0, 1'b0, 1'b0, 1'b0);
    set2(2'b00, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_single_pulse();
    test_illegal();
    test_busy_request();
    test_reset_mid_drive();
    test_small_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
